// File: rtl/column_reducer_multi.sv
`default_nettype none
// ============================================================================
// Module      : column_reducer_multi
// Description : Buffers one column of unsigned numbers (up to DEPTH), latches
//               a reduction op (ADD/MUL/MIN/MAX) that may arrive any time up
//               to and including done, then folds the column one element per
//               cycle and presents the result with ready/valid handshaking.
// Ports       : clk, rst (sync, active-high)
//               num_valid/num_in, op_valid/op_in, done   -> column input
//               in_ready                                 <- high in COLLECT
//               result_valid/result_ready                -> output handshake
//               result, result_count, overflow, dropped  -> column result
// Notes       : Requires DEPTH >= 2 and ACC_W > DATA_W.
// Revision    : 1.0 - initial release
// ============================================================================
module column_reducer_multi #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64,
    parameter int DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         num_valid,
    input  logic [DATA_W-1:0]            num_in,
    input  logic                         op_valid,
    input  logic [1:0]                   op_in,
    input  logic                         done,
    output logic                         in_ready,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic [ACC_W-1:0]             result,
    output logic [$clog2(DEPTH+1)-1:0]   result_count,
    output logic                         overflow,
    output logic                         dropped
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

    localparam logic [1:0] c_OP_ADD = 2'd0;
    localparam logic [1:0] c_OP_MUL = 2'd1;
    localparam logic [1:0] c_OP_MIN = 2'd2;
    localparam logic [1:0] c_OP_MAX = 2'd3;

    localparam logic [1:0] c_ST_COLLECT = 2'd0;
    localparam logic [1:0] c_ST_REDUCE  = 2'd1;
    localparam logic [1:0] c_ST_OUT     = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        r_idx;
    logic [1:0]              r_op;
    logic [ACC_W-1:0]        r_acc;
    logic                    r_ovf;
    logic                    r_dropped;
    logic [DATA_W-1:0]       r_buf [DEPTH];

    logic                    w_collect;
    logic                    w_has_room;
    logic                    w_num_accept;
    logic [1:0]              w_op_eff;
    logic [CNT_W-1:0]        w_count_eff;
    logic                    w_fold;
    logic [DATA_W-1:0]       w_elem;
    logic [ACC_W-1:0]        w_elem_ext;
    logic [ACC_W+DATA_W-1:0] w_prod;
    logic [ACC_W:0]          w_sum;

    assign w_collect    = (r_state == c_ST_COLLECT);
    assign w_has_room   = (r_count < c_DEPTH);
    assign w_num_accept = w_collect && num_valid && w_has_room;

    // Op and element count as they will stand after this edge, so that a
    // number or op arriving together with done is part of the column.
    assign w_op_eff    = op_valid ? op_in : r_op;
    assign w_count_eff = w_num_accept ? (r_count + CNT_W'(1)) : r_count;

    // Fold while unread elements remain; r_idx == r_count ends the reduction.
    assign w_fold     = (r_state == c_ST_REDUCE) && (r_idx != r_count);
    assign w_elem     = r_buf[r_idx[IDX_W-1:0]];
    assign w_elem_ext = {{(ACC_W-DATA_W){1'b0}}, w_elem};
    assign w_prod     = {{DATA_W{1'b0}}, r_acc} * {{ACC_W{1'b0}}, w_elem};
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_elem_ext};

    // ------------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_COLLECT: if (done)              w_state_next = c_ST_REDUCE;
            c_ST_REDUCE:  if (r_idx == r_count)  w_state_next = c_ST_OUT;
            c_ST_OUT:     if (result_ready)      w_state_next = c_ST_COLLECT;
            default:                             w_state_next = c_ST_COLLECT;
        endcase
    end

    // ------------------------------------------------------------------------
    // Column buffer (no reset needed; only slots below r_count are read)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && w_num_accept) begin
            r_buf[r_count[IDX_W-1:0]] <= num_in;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_idx     <= '0;
            r_op      <= c_OP_ADD;
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            case (r_state)
                c_ST_COLLECT: begin
                    if (num_valid && !w_has_room) begin
                        r_dropped <= 1'b1;
                    end
                    r_count <= w_count_eff;
                    r_op    <= w_op_eff;
                    if (done) begin
                        r_idx <= '0;
                        // MUL starts from 1; an empty column always reports 0.
                        // MIN/MAX load element 0 directly, so their seed is moot.
                        r_acc <= (w_op_eff == c_OP_MUL && w_count_eff != '0)
                                 ? ACC_W'(1) : '0;
                    end
                end
                c_ST_REDUCE: begin
                    if (w_fold) begin
                        r_idx <= r_idx + CNT_W'(1);
                        case (r_op)
                            c_OP_ADD: begin
                                r_acc <= w_sum[ACC_W-1:0];
                                if (w_sum[ACC_W]) r_ovf <= 1'b1;
                            end
                            c_OP_MUL: begin
                                r_acc <= w_prod[ACC_W-1:0];
                                if (w_prod[ACC_W+DATA_W-1:ACC_W] != '0) r_ovf <= 1'b1;
                            end
                            c_OP_MIN: begin
                                if (r_idx == '0 || w_elem_ext < r_acc) r_acc <= w_elem_ext;
                            end
                            default: begin
                                if (r_idx == '0 || w_elem_ext > r_acc) r_acc <= w_elem_ext;
                            end
                        endcase
                    end
                end
                c_ST_OUT: begin
                    if (result_ready) begin
                        r_count   <= '0;
                        r_idx     <= '0;
                        r_op      <= c_OP_ADD;
                        r_acc     <= '0;
                        r_ovf     <= 1'b0;
                        r_dropped <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = w_collect;
    assign result_valid = (r_state == c_ST_OUT);
    assign result       = r_acc;
    assign result_count = r_count;
    assign overflow     = r_ovf;
    assign dropped      = r_dropped;

endmodule
`default_nettype wire
